// File: rtl/mem_arbiter.sv
// Two-master arbiter (fetch and load/store) in front of one shared memory channel.
// Only one transaction is in flight; data wins ties unless fetch has been passed over twice.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam logic [1:0] STARVE_MAX = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  starve_q, starve_d;
    logic [1:0]  owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        in_idle;
    logic        grant_data;
    logic        grant_inst;
    logic        done;

    // Grants are suppressed while reset is high so no handshake is lost to the clear.
    always_comb begin
        in_idle    = (state_q == IDLE) && !reset;
        grant_data = in_idle && data_req && !((starve_q == STARVE_MAX) && inst_req);
        grant_inst = in_idle && inst_req && !grant_data;
        done       = (state_q == DATA) && mem_data_ok && !reset;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d  = ADDR;
                    owner_d  = OWN_DATA;
                    wr_d     = data_wr;
                    size_d   = data_size;
                    wstrb_d  = data_wstrb;
                    addr_d   = data_addr;
                    wdata_d  = data_wdata;
                    if (!inst_req) begin
                        starve_d = 2'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (grant_inst) begin
                    state_d  = ADDR;
                    owner_d  = OWN_INST;
                    wr_d     = 1'b0;
                    size_d   = 2'd2;
                    wstrb_d  = 4'h0;
                    addr_d   = inst_addr;
                    wdata_d  = 32'h0;
                    starve_d = 2'd0;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= 2'd0;
            owner_q  <= OWN_NONE;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;

        mem_req   = (state_q == ADDR) && !reset;
        mem_wr    = wr_q;
        mem_size  = size_q;
        mem_wstrb = wstrb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;

        inst_data_ok = done && (owner_q == OWN_INST);
        data_data_ok = done && (owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: one table row per clock cycle,
// plus hand-written sequences for reset, byte stores and reset during a transaction.
module tb_mem_arbiter;

    localparam logic        N   = 1'b0;
    localparam logic        Y   = 1'b1;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [3:0]  Z4  = 4'h0;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [3:0]  dwstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
        logic        x_iaok;
        logic        x_daok;
        logic        x_idok;
        logic        x_ddok;
        logic [31:0] x_rdata;
        logic        x_mreq;
        logic        x_mwr;
        logic [31:0] x_maddr;
        logic [31:0] x_mwdata;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic put(input logic ireq, input logic [31:0] iaddr, input logic dreq, input logic dwr,
                       input logic [3:0] dwstrb, input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic maok, input logic mdok, input logic [31:0] mrdata,
                       input logic x_iaok, input logic x_daok, input logic x_idok, input logic x_ddok,
                       input logic [31:0] x_rdata, input logic x_mreq, input logic x_mwr,
                       input logic [31:0] x_maddr, input logic [31:0] x_mwdata);
        vec_t v;
        v.ireq = ireq;     v.iaddr = iaddr;   v.dreq = dreq;     v.dwr = dwr;
        v.dwstrb = dwstrb; v.daddr = daddr;   v.dwdata = dwdata;
        v.maok = maok;     v.mdok = mdok;     v.mrdata = mrdata;
        v.x_iaok = x_iaok; v.x_daok = x_daok; v.x_idok = x_idok; v.x_ddok = x_ddok;
        v.x_rdata = x_rdata; v.x_mreq = x_mreq; v.x_mwr = x_mwr;
        v.x_maddr = x_maddr; v.x_mwdata = x_mwdata;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic        gi;
    logic [31:0] rd;

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        idle_inputs();

        // Reset held two cycles; on the second one, requests must not be granted.
        next_cycle();
        inst_req = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        chk("rst_inst_addr_ok", {31'h0, inst_addr_ok}, Z);
        chk("rst_data_addr_ok", {31'h0, data_addr_ok}, Z);
        chk("rst_mem_req", {31'h0, mem_req}, Z);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, Z);
        chk("rst_mem_fields", {25'h0, mem_wr, mem_size, mem_wstrb}, Z);
        chk("rst_mem_wdata", mem_wdata, Z);
        chk("rst_data_ok", {30'h0, inst_data_ok, data_data_ok}, Z);
        chk("rst_rdata", inst_rdata | data_rdata, Z);
        next_cycle();

        // Single fetch at minimum latency.
        put(Y, 32'h1C000000, N, N, Z4, Z, Z, N, N, Z,            Y, N, N, N, Z, N, N, Z, Z);
        put(N, Z, N, N, Z4, Z, Z, Y, N, Z,                       N, N, N, N, Z, Y, N, 32'h1C000000, Z);
        put(N, Z, N, N, Z4, Z, Z, N, Y, 32'h02800C0C,            N, N, Y, N, 32'h02800C0C, N, N, Z, Z);
        put(N, Z, N, N, Z4, Z, Z, N, N, Z,                       N, N, N, N, Z, N, N, Z, Z);
        // Collision: store wins, fetch stays pending and is granted at the next IDLE.
        put(Y, 32'h2000, Y, Y, 4'hF, 32'h100, 32'hDEADBEEF, N, N, Z, N, Y, N, N, Z, N, N, Z, Z);
        put(Y, 32'h2000, N, N, Z4, Z, Z, Y, N, Z,                N, N, N, N, Z, Y, Y, 32'h100, 32'hDEADBEEF);
        put(Y, 32'h2000, N, N, Z4, Z, Z, N, Y, 32'h12345678,     N, N, N, Y, 32'h12345678, N, N, Z, Z);
        put(Y, 32'h2000, N, N, Z4, Z, Z, N, N, Z,                Y, N, N, N, Z, N, N, Z, Z);
        put(N, Z, N, N, Z4, Z, Z, Y, N, Z,                       N, N, N, N, Z, Y, N, 32'h2000, Z);
        put(N, Z, N, N, Z4, Z, Z, N, Y, 32'hCAFEF00D,            N, N, Y, N, 32'hCAFEF00D, N, N, Z, Z);
        // Stray mem_data_ok in IDLE is ignored.
        put(N, Z, N, N, Z4, Z, Z, N, Y, 32'hFFFFFFFF,            N, N, N, N, Z, N, N, Z, Z);
        // Load with six ADDR cycles of backpressure; both requests pending throughout.
        put(N, Z, Y, N, Z4, 32'h40, Z, N, N, Z,                  N, Y, N, N, Z, N, N, Z, Z);
        put(Y, 32'h3000, Y, N, Z4, 32'h40, Z, N, Y, 32'h11111111, N, N, N, N, Z, Y, N, 32'h40, Z);
        for (int i = 0; i < 4; i++) begin
            put(Y, 32'h3000, Y, N, Z4, 32'h40, Z, N, N, Z,       N, N, N, N, Z, Y, N, 32'h40, Z);
        end
        put(Y, 32'h3000, Y, N, Z4, 32'h40, Z, Y, N, Z,           N, N, N, N, Z, Y, N, 32'h40, Z);
        put(Y, 32'h3000, Y, N, Z4, 32'h40, Z, N, Y, 32'hA5A5A5A5, N, N, N, Y, 32'hA5A5A5A5, N, N, Z, Z);
        // Both held: grant order data, data, inst, data, data, inst.
        for (int k = 0; k < 6; k++) begin
            gi = (k % 3 == 2);
            rd = 32'(k + 1);
            put(Y, 32'h3000, Y, N, Z4, 32'h200, Z, N, N, Z,      gi, !gi, N, N, Z, N, N, Z, Z);
            put(Y, 32'h3000, Y, N, Z4, 32'h200, Z, Y, N, Z,      N, N, N, N, Z, Y, N, gi ? 32'h3000 : 32'h200, Z);
            put(Y, 32'h3000, Y, N, Z4, 32'h200, Z, N, Y, rd,     N, N, gi, !gi, rd, N, N, Z, Z);
        end
        put(N, Z, N, N, Z4, Z, Z, N, N, Z,                       N, N, N, N, Z, N, N, Z, Z);

        foreach (vecs[i]) begin
            inst_req    = vecs[i].ireq;
            inst_addr   = vecs[i].iaddr;
            data_req    = vecs[i].dreq;
            data_wr     = vecs[i].dwr;
            data_size   = 2'd2;
            data_wstrb  = vecs[i].dwstrb;
            data_addr   = vecs[i].daddr;
            data_wdata  = vecs[i].dwdata;
            mem_addr_ok = vecs[i].maok;
            mem_data_ok = vecs[i].mdok;
            mem_rdata   = vecs[i].mrdata;
            @(negedge clk);
            chk($sformatf("v%0d_inst_addr_ok", i), {31'h0, inst_addr_ok}, {31'h0, vecs[i].x_iaok});
            chk($sformatf("v%0d_data_addr_ok", i), {31'h0, data_addr_ok}, {31'h0, vecs[i].x_daok});
            chk($sformatf("v%0d_inst_data_ok", i), {31'h0, inst_data_ok}, {31'h0, vecs[i].x_idok});
            chk($sformatf("v%0d_data_data_ok", i), {31'h0, data_data_ok}, {31'h0, vecs[i].x_ddok});
            chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].x_idok ? vecs[i].x_rdata : Z);
            chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].x_ddok ? vecs[i].x_rdata : Z);
            chk($sformatf("v%0d_mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].x_mreq});
            if (vecs[i].x_mreq) begin
                chk($sformatf("v%0d_mem_wr", i), {31'h0, mem_wr}, {31'h0, vecs[i].x_mwr});
                chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].x_maddr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].x_mwdata);
            end
            next_cycle();
        end

        // Byte store: size and strobes pass through unchanged.
        idle_inputs();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0010;
        data_addr = 32'h41; data_wdata = 32'h0000AB00;
        @(negedge clk);
        chk("byte_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
        next_cycle();
        idle_inputs();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("byte_mem_req", {31'h0, mem_req}, 32'h1);
        chk("byte_mem_size", {30'h0, mem_size}, 32'h0);
        chk("byte_mem_wstrb", {28'h0, mem_wstrb}, 32'h2);
        chk("byte_mem_addr", mem_addr, 32'h41);
        chk("byte_mem_wdata", mem_wdata, 32'h0000AB00);
        next_cycle();
        idle_inputs();
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk("byte_data_data_ok", {31'h0, data_data_ok}, 32'h1);
        next_cycle();

        // Fetch abandoned by reset in DATA; the late response must be dropped.
        idle_inputs();
        inst_req = 1'b1; inst_addr = 32'h5000;
        @(negedge clk);
        chk("rmf_inst_addr_ok", {31'h0, inst_addr_ok}, 32'h1);
        next_cycle();
        idle_inputs();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("rmf_mem_size", {30'h0, mem_size}, 32'h2);
        chk("rmf_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        chk("rmf_rst_inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
        next_cycle();
        reset = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("rmf_late_inst_data_ok", {31'h0, inst_data_ok}, 32'h0);
        chk("rmf_late_data_data_ok", {31'h0, data_data_ok}, 32'h0);
        chk("rmf_late_inst_rdata", inst_rdata, 32'h0);
        chk("rmf_late_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rmf_late_mem_addr", mem_addr, 32'h0);
        next_cycle();
        idle_inputs();
        data_req = 1'b1; data_addr = 32'h80;
        @(negedge clk);
        chk("rmf_idle_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
        next_cycle();
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have no parameters; data widths are fixed at 32 bits.
REQ-002 The module SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  clock; reset is synchronous, active-high.
- reset  in  1  clears all state.
- inst_req  in  1  fetch read request.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted.
- inst_data_ok  out  1  fetch read data valid.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  load/store request.
- data_wr  in  1  1 = write.
- data_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- data_wstrb  in  4  byte write strobes.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  load/store request accepted.
- data_data_ok  out  1  load data valid, or store completed.
- data_rdata  out  32  load data.
- mem_req, mem_wr, mem_size[1:0], mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  shared memory request channel.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory response valid.
- mem_rdata  in  32  memory read data.

Function
REQ-003 The FSM SHALL have three states: IDLE, ADDR and DATA. At most one transaction SHALL be outstanding at any time.
REQ-004 In IDLE with at least one request pending, the arbiter SHALL grant exactly one requester, pulse that requester's addr_ok for one cycle (combinationally, in the same cycle), latch the request fields and the owner, and move to ADDR on the next cycle.
REQ-005 Grant priority SHALL be data over inst, except when the starvation counter is 2 and inst_req is high; in that case inst SHALL be granted.
REQ-006 Starvation counter (2 bits):
- increments on a data grant while inst_req is high;
- clears on any inst grant;
- clears on a data grant while inst_req is low;
- saturates at 2.
REQ-007 In IDLE with no request pending, all addr_ok outputs SHALL be 0 and the state SHALL remain IDLE.
REQ-008 In ADDR, the arbiter SHALL drive mem_req=1 with the latched fields held stable. It SHALL move to DATA on the cycle after mem_addr_ok=1, and remain in ADDR otherwise.
REQ-009 For an inst grant, the latched fields SHALL be: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
REQ-010 Outside ADDR, mem_req SHALL be 0.
REQ-011 In DATA, when mem_data_ok=1:
- the owner's data_ok SHALL be 1 in the same cycle;
- the owner's rdata SHALL equal mem_rdata in the same cycle;
- the state SHALL return to IDLE on the next cycle.
REQ-012 The non-owner's data_ok SHALL be 0 at all times.
REQ-013 mem_data_ok SHALL be ignored outside DATA.
REQ-014 New grants SHALL NOT occur while in ADDR or DATA. Minimum gap between consecutive grants: 3 cycles (IDLE -> ADDR -> DATA -> IDLE).
REQ-015 Minimum latency: accepted at cycle T, mem_req at T+1, owner data_ok at T+2 (with mem_addr_ok at T+1 and mem_data_ok at T+2).
REQ-016 Simultaneous inst_req and data_req in IDLE SHALL resolve per REQ-005 within the same cycle. The losing request SHALL receive addr_ok=0 and remain pending.
REQ-017 inst_rdata and data_rdata SHALL be 0 whenever the corresponding data_ok is 0.

Reset
REQ-018 Reset SHALL force:
- state = IDLE, starvation counter = 0, owner = none;
- latched fields = 0;
- all outputs = 0 from the cycle after reset is sampled high.
REQ-019 Reset asserted in ADDR or DATA SHALL abandon the transaction without any data_ok pulse. A mem_data_ok arriving after reset SHALL be ignored.

Verification
REQ-020 Single fetch:
- stimulus: inst_req=1 with inst_addr=0x1C000000 at cycle T; mem_addr_ok=1 at T+1; mem_data_ok=1 with mem_rdata=0x02800C0C at T+2;
- response: inst_addr_ok=1 at T; mem_req=1 with mem_addr=0x1C000000 at T+1; inst_data_ok=1 with inst_rdata=0x02800C0C at T+2.
REQ-021 Collision:
- stimulus: inst_req and data_req both 1 at T; data_addr=0x100, data_wr=1, data_wstrb=0xF, data_wdata=0xDEADBEEF;
- response: data_addr_ok=1 and inst_addr_ok=0 at T; mem_wr=1 with mem_wdata=0xDEADBEEF at T+1; inst is granted at the first IDLE after data_data_ok.
REQ-022 Starvation:
- stimulus: inst_req and data_req held at 1 continuously, memory responding at minimum latency;
- response: grant order is data, data, inst, data, data, inst.
REQ-023 Memory backpressure:
- stimulus: mem_addr_ok held 0 for 5 cycles, then 1;
- response: mem_req and all mem_* fields are stable for all 6 ADDR cycles; no addr_ok is pulsed during this time.
REQ-024 Reset mid-flight:
- stimulus: reset=1 during DATA; mem_data_ok=1 on the following cycle;
- response: inst_data_ok=0, data_data_ok=0, mem_req=0, state returns to IDLE.
